// File: rtl/m_sipo10_if.sv
// Bit-stream and word handshake bundle for the 10-bit deserialiser.
// The master drives the serial stream and acknowledges words.
// The slave (the deserialiser) returns the word and the status flags.
interface m_sipo10_if;
    logic       SHIFT_EN;
    logic       SIN;
    logic       FRAME;
    logic       QACK;
    logic [9:0] Q;
    logic       QVALID;
    logic       ALLONES;
    logic       OVERRUN;
    logic       FRAMEERR;

    modport master (
        output SHIFT_EN, SIN, FRAME, QACK,
        input  Q, QVALID, ALLONES, OVERRUN, FRAMEERR
    );

    modport slave (
        input  SHIFT_EN, SIN, FRAME, QACK,
        output Q, QVALID, ALLONES, OVERRUN, FRAMEERR
    );
endinterface

// File: rtl/m_sipo10.sv
// Serial-in, parallel-out 10-bit word deserialiser.
// Words are framed by FRAME on their first (MSB) bit and then run back-to-back.
// Each completed word goes to a held register with a valid/ack handshake and a
// registered all-ones flag. All outputs are registered.
module m_sipo10 (
    input logic       MasterClock,
    input logic       Reset,
    m_sipo10_if.slave bus
);

    logic [9:0] sr_q;
    logic [3:0] cnt_q;
    logic       sync_q;
    logic       frameerr_q;

    logic [9:0] q_q;
    logic       qvalid_q;
    logic       allones_q;
    logic       overrun_q;

    logic [9:0] word;
    logic       complete;
    logic       accept;

    // Completed word is the 9 held bits plus the bit being sampled now.
    // FRAME on the 10th bit restarts framing, so that edge is not a completion.
    always_comb begin
        word     = {sr_q[8:0], bus.SIN};
        complete = bus.SHIFT_EN && !bus.FRAME && sync_q && (cnt_q == 4'd9);
        accept   = complete && (!qvalid_q || bus.QACK);
    end

    // Shift register, bit counter, sync flag and the frame-error pulse.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            sync_q     <= 1'b0;
            frameerr_q <= 1'b0;
        end else begin
            frameerr_q <= 1'b0;
            if (bus.SHIFT_EN) begin
                if (bus.FRAME) begin
                    // Word start; a partial word in progress is an error and is dropped.
                    frameerr_q <= sync_q && (cnt_q != 4'd0);
                    sr_q       <= {9'd0, bus.SIN};
                    cnt_q      <= 4'd1;
                    sync_q     <= 1'b1;
                end else if (sync_q) begin
                    sr_q  <= word;
                    cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
                end
            end
        end
    end

    // Output word register, handshake and sticky overrun.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            q_q       <= '0;
            qvalid_q  <= 1'b0;
            allones_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                q_q       <= word;
                allones_q <= &word;
                qvalid_q  <= 1'b1;
            end else if (complete) begin
                // Unacknowledged word still held: drop the new one.
                overrun_q <= 1'b1;
            end else if (qvalid_q && bus.QACK) begin
                qvalid_q <= 1'b0;
            end
        end
    end

    assign bus.Q        = q_q;
    assign bus.QVALID   = qvalid_q;
    assign bus.ALLONES  = allones_q;
    assign bus.OVERRUN  = overrun_q;
    assign bus.FRAMEERR = frameerr_q;

endmodule

// File: tb/tb_m_sipo10.sv
// Directed self-checking bench for the 10-bit deserialiser.
module tb_m_sipo10;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    m_sipo10_if bus ();

    m_sipo10 dut (
        .MasterClock (clk),
        .Reset       (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All drives and samples happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.SHIFT_EN = 1'b0;
        bus.SIN      = 1'b0;
        bus.FRAME    = 1'b0;
        bus.QACK     = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic f);
        bus.SHIFT_EN = 1'b1;
        bus.SIN      = b;
        bus.FRAME    = f;
        tick();
        bus.FRAME    = 1'b0;
    endtask

    task automatic idle();
        bus.SHIFT_EN = 1'b0;
        bus.FRAME    = 1'b0;
        bus.QACK     = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input logic framed);
        for (int i = 9; i >= 0; i--) send_bit(w[i], framed && (i == 9));
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        tests++; if (bus.Q !== 10'h000) begin fails++; $display("FAIL reset_q: got %h want %h", bus.Q, 10'h000); end
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL reset_qvalid: got %b want 0", bus.QVALID); end
        tests++; if (bus.ALLONES !== 1'b0) begin fails++; $display("FAIL reset_allones: got %b want 0", bus.ALLONES); end
        tests++; if (bus.OVERRUN !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", bus.OVERRUN); end
        tests++; if (bus.FRAMEERR !== 1'b0) begin fails++; $display("FAIL reset_frameerr: got %b want 0", bus.FRAMEERR); end
    endtask

    task automatic test_basic();
        logic [9:0] w;
        w = 10'b1011001110;
        do_reset();
        for (int i = 9; i >= 1; i--) send_bit(w[i], i == 9);
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", bus.QVALID); end
        send_bit(w[0], 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h2CE) begin fails++; $display("FAIL basic_q: got %h want %h", bus.Q, 10'h2CE); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL basic_qvalid: got %b want 1", bus.QVALID); end
        tests++; if (bus.ALLONES !== 1'b0) begin fails++; $display("FAIL basic_allones: got %b want 0", bus.ALLONES); end
        bus.QACK = 1'b1;
        tick();
        bus.QACK = 1'b0;
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL basic_ack_clear: got %b want 0", bus.QVALID); end
        tests++; if (bus.Q !== 10'h2CE) begin fails++; $display("FAIL basic_q_hold: got %h want %h", bus.Q, 10'h2CE); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        w = 10'h155;
        do_reset();
        send_word(10'h3FF, 1'b1);
        tests++; if (bus.Q !== 10'h3FF) begin fails++; $display("FAIL b2b_q1: got %h want %h", bus.Q, 10'h3FF); end
        tests++; if (bus.ALLONES !== 1'b1) begin fails++; $display("FAIL b2b_allones1: got %b want 1", bus.ALLONES); end
        // Acknowledge alongside the first bit of the next word.
        bus.QACK = 1'b1;
        send_bit(w[9], 1'b0);
        bus.QACK = 1'b0;
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL b2b_ack: got %b want 0", bus.QVALID); end
        for (int i = 8; i >= 0; i--) send_bit(w[i], 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h155) begin fails++; $display("FAIL b2b_q2: got %h want %h", bus.Q, 10'h155); end
        tests++; if (bus.ALLONES !== 1'b0) begin fails++; $display("FAIL b2b_allones2: got %b want 0", bus.ALLONES); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL b2b_qvalid2: got %b want 1", bus.QVALID); end
        tests++; if (bus.OVERRUN !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b want 0", bus.OVERRUN); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(10'h3FF, 1'b1);
        tests++; if (bus.OVERRUN !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b want 0", bus.OVERRUN); end
        send_word(10'h000, 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h3FF) begin fails++; $display("FAIL ovr_q_hold: got %h want %h", bus.Q, 10'h3FF); end
        tests++; if (bus.ALLONES !== 1'b1) begin fails++; $display("FAIL ovr_allones_hold: got %b want 1", bus.ALLONES); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL ovr_qvalid: got %b want 1", bus.QVALID); end
        tests++; if (bus.OVERRUN !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", bus.OVERRUN); end
        bus.QACK = 1'b1;
        tick();
        bus.QACK = 1'b0;
        tick();
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL ovr_ack: got %b want 0", bus.QVALID); end
        tests++; if (bus.OVERRUN !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", bus.OVERRUN); end
        do_reset();
        tests++; if (bus.OVERRUN !== 1'b0) begin fails++; $display("FAIL ovr_reset: got %b want 0", bus.OVERRUN); end
    endtask

    task automatic test_frameerr();
        logic [9:0] w;
        w = 10'h2A5;
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        tests++; if (bus.FRAMEERR !== 1'b0) begin fails++; $display("FAIL ferr_none: got %b want 0", bus.FRAMEERR); end
        send_bit(w[9], 1'b1);
        tests++; if (bus.FRAMEERR !== 1'b1) begin fails++; $display("FAIL ferr_pulse: got %b want 1", bus.FRAMEERR); end
        send_bit(w[8], 1'b0);
        tests++; if (bus.FRAMEERR !== 1'b0) begin fails++; $display("FAIL ferr_one_cycle: got %b want 0", bus.FRAMEERR); end
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h2A5) begin fails++; $display("FAIL ferr_q: got %h want %h", bus.Q, 10'h2A5); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL ferr_qvalid: got %b want 1", bus.QVALID); end
        // Aligned FRAME at a word boundary is not an error.
        bus.QACK = 1'b1;
        send_bit(1'b0, 1'b1);
        bus.QACK = 1'b0;
        tests++; if (bus.FRAMEERR !== 1'b0) begin fails++; $display("FAIL ferr_aligned: got %b want 0", bus.FRAMEERR); end
        idle();
    endtask

    task automatic test_unsync_and_reset();
        do_reset();
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        idle();
        tick();
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL unsync_valid: got %b want 0", bus.QVALID); end
        send_word(10'h3FF, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        idle();
        do_reset();
        tests++; if (bus.Q !== 10'h000) begin fails++; $display("FAIL rst_mid_q: got %h want %h", bus.Q, 10'h000); end
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL rst_mid_qvalid: got %b want 0", bus.QVALID); end
        tests++; if (bus.ALLONES !== 1'b0) begin fails++; $display("FAIL rst_mid_allones: got %b want 0", bus.ALLONES); end
        // Sync is lost: unframed bits are ignored, including enough to finish the old word.
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        idle();
        tick();
        tests++; if (bus.QVALID !== 1'b0) begin fails++; $display("FAIL rst_mid_unsync: got %b want 0", bus.QVALID); end
        send_word(10'h1C3, 1'b1);
        idle();
        tests++; if (bus.Q !== 10'h1C3) begin fails++; $display("FAIL rst_mid_resync_q: got %h want %h", bus.Q, 10'h1C3); end
    endtask

    task automatic test_ack_on_completion();
        logic [9:0] w;
        w = 10'h30F;
        do_reset();
        send_word(10'h0F0, 1'b1);
        for (int i = 9; i >= 1; i--) send_bit(w[i], 1'b0);
        bus.QACK = 1'b1;
        send_bit(w[0], 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h30F) begin fails++; $display("FAIL ackc_q: got %h want %h", bus.Q, 10'h30F); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL ackc_qvalid: got %b want 1", bus.QVALID); end
        tests++; if (bus.OVERRUN !== 1'b0) begin fails++; $display("FAIL ackc_overrun: got %b want 0", bus.OVERRUN); end
    endtask

    task automatic test_gap();
        logic [9:0] w;
        w = 10'h19B;
        do_reset();
        for (int i = 9; i >= 5; i--) send_bit(w[i], i == 9);
        // SHIFT_EN low: SIN and FRAME must be ignored.
        bus.SHIFT_EN = 1'b0;
        bus.FRAME    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.SIN = i[0];
            tick();
        end
        bus.FRAME = 1'b0;
        tests++; if (bus.FRAMEERR !== 1'b0) begin fails++; $display("FAIL gap_frameerr: got %b want 0", bus.FRAMEERR); end
        for (int i = 4; i >= 0; i--) send_bit(w[i], 1'b0);
        idle();
        tests++; if (bus.Q !== 10'h19B) begin fails++; $display("FAIL gap_q: got %h want %h", bus.Q, 10'h19B); end
        tests++; if (bus.QVALID !== 1'b1) begin fails++; $display("FAIL gap_qvalid: got %b want 1", bus.QVALID); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle();
        bus.SIN = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frameerr();
        test_unsync_and_reset();
        test_ack_on_completion();
        test_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m_sipo10.md
# m_sipo10

Serial-in, parallel-out 10-bit word deserialiser with framing, a valid/acknowledge handshake and all-ones detection. It collects a serial bit stream into 10-bit words for Slipstream-side logic. It presents each completed word on a held parallel register, alongside a registered all-ones match flag that replaces a separate 10-input AND decode downstream.

## Interface
Parameters: none. Width is fixed at 10.
- MasterClock  in  1  system clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high reset
- SHIFT_EN  in  1  bit strobe; SIN and FRAME are sampled only on edges where SHIFT_EN=1
- SIN  in  1  serial data bit, MSB first
- FRAME  in  1  qualified by SHIFT_EN; marks the current SIN bit as bit 9 (first bit) of a new word
- QACK  in  1  consumer acknowledge of the current word
- Q  out  10  last completed word
- QVALID  out  1  Q holds an unacknowledged word
- ALLONES  out  1  registered AND of all 10 bits of Q
- OVERRUN  out  1  sticky; a completed word was dropped
- FRAMEERR  out  1  one-cycle pulse; FRAME arrived mid-word

## Operation
- Internal state: 10-bit shift register SR, 4-bit bit counter CNT (0..9), sync flag SYNC.
- Unsynchronised (SYNC=0):
  - Bits with FRAME=0 are ignored.
  - A bit with FRAME=1 sets SYNC=1, loads SR[0]=SIN and sets CNT=1.
- Synchronised (SYNC=1), normal shift: each bit with FRAME=0 shifts SR left, takes SIN into bit 0, and increments CNT.
- Word completion: on the 10th bit (CNT=9), the word {SR[8:0],SIN} completes and CNT returns to 0. Words continue back-to-back; no FRAME is required.
- Resynchronisation: FRAME=1 while CNT≠0 and SYNC=1:
  - the partial word is discarded;
  - FRAMEERR pulses;
  - SIN becomes bit 9 of a new word and CNT=1.
- FRAME=1 at CNT=0 is a correctly aligned word start; no error.
- Handshake:
  - On completion with QVALID=0, or with QVALID=1 and QACK=1 on the same edge: Q is loaded, ALLONES is set to the AND of the new word, and QVALID=1.
  - On completion with QVALID=1 and QACK=0: the new word is dropped, Q and ALLONES hold, QVALID stays 1 and OVERRUN is set.
  - QACK=1 with QVALID=1 and no completion: QVALID clears.
  - QACK with QVALID=0 has no effect.
- OVERRUN clears only on Reset.
- Reset values: Q=0, QVALID=0, ALLONES=0, OVERRUN=0, FRAMEERR=0, SR=0, CNT=0, SYNC=0.
- Reset has priority over all other inputs. Reset mid-word discards the partial word and returns to the unsynchronised state.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: the edge that samples the 10th bit updates Q, ALLONES and QVALID at that same edge. They are visible in the following cycle.
- FRAMEERR is high for exactly the one cycle after the offending edge.
- QVALID falls the cycle after the edge on which QACK is sampled high, unless a completion occurs on that same edge.
- The minimum word period is 10 cycles with SHIFT_EN held high continuously; gaps in SHIFT_EN of any length are allowed.
- SHIFT_EN=0 freezes SR, CNT and SYNC. QACK is still honoured while SHIFT_EN=0.

## Test plan
- Reset, then FRAME on first bit, serial 10'b1011001110 MSB first with SHIFT_EN continuous -> Q=0x2CE, QVALID=1, ALLONES=0 one cycle after the 10th bit.
- Word 0x3FF followed immediately by 0x155, with QACK pulsed between words -> first Q=0x3FF with ALLONES=1; then Q=0x155 with ALLONES=0; no OVERRUN.
- Two words with no QACK -> Q stays at the first word, OVERRUN=1 after the second completion and persists until Reset.
- FRAME asserted on the 4th bit of a word -> FRAMEERR pulses for one cycle; the next 10 bits from that point form Q; the partial word never appears.
- Bits sent with FRAME=0 before any FRAME -> no QVALID. Then Reset asserted mid-word after sync -> all outputs 0 and SYNC cleared; subsequent bits are ignored until FRAME.
- QACK on the same edge as word completion, with QVALID=1 -> Q updates to the new word, QVALID stays 1, OVERRUN=0.
